coin_credit_controller: RTL and testbench

//  Front-end payment stage that sits directly upstream of the washer FSM.

---
 rtl/coin_credit_controller.sv | 179 +++++++++++++++++
 tb/tb_coin_credit_controller.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_credit_controller.sv
`default_nettype none
// ============================================================================
// Module   : coin_credit_controller
// Brief    : Coin debounce, credit accumulation, price check and start/refund
//            sequencing in front of the washer FSM.
// Revision : 1.0 - initial release
// ============================================================================
module coin_credit_controller #(
    parameter int PRICE_SINGLE    = 2,
    parameter int PRICE_DOUBLE    = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CREDIT_W        = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_sense,
    input  logic                double_wash_req,
    input  logic                start_req,
    input  logic                cancel_req,
    input  logic                wash_done,
    output logic                coin_in,
    output logic                double_wash,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                refund_pulse,
    output logic                cycle_complete
);

    localparam int                  c_DB_W       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_DB_W-1:0]   c_DB_LAST    = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CREDIT_W-1:0] c_PRICE_S    = CREDIT_W'(PRICE_SINGLE);
    localparam logic [CREDIT_W-1:0] c_PRICE_D    = CREDIT_W'(PRICE_DOUBLE);
    localparam logic [CREDIT_W-1:0] c_CREDIT_MAX = {CREDIT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_START   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_REFUND  = 2'd3
    } state_t;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_db_level;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              r_coin_evt;

    // Counter only advances while the synced level disagrees with the
    // debounced level; any agreement (a bounce) reloads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_level <= 1'b0;
            r_db_cnt   <= '0;
            r_coin_evt <= 1'b0;
        end else begin
            r_sync1    <= coin_sense;
            r_sync2    <= r_sync1;
            r_coin_evt <= 1'b0;
            if (r_sync2 == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_db_level <= r_sync2;
                r_db_cnt   <= '0;
                r_coin_evt <= r_sync2;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_wash_done_q;
    logic                r_refund_gap;
    logic                w_refund_gap_nxt;
    logic                w_done_rise;
    logic [CREDIT_W-1:0] w_price;
    logic [CREDIT_W-1:0] w_base;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic                w_dw_nxt;
    logic                w_coin_in_nxt;
    logic                w_reject_nxt;
    logic                w_refund_nxt;
    logic                w_complete_nxt;

    assign w_price     = double_wash_req ? c_PRICE_D : c_PRICE_S;
    assign w_done_rise = wash_done & ~r_wash_done_q;
    assign busy        = (r_state == ST_START) || (r_state == ST_BUSY);

    always_comb begin
        w_state_nxt      = r_state;
        w_refund_gap_nxt = r_refund_gap;
        w_base           = credit;
        w_credit_nxt     = credit;
        w_dw_nxt         = double_wash;
        w_coin_in_nxt    = 1'b0;
        w_reject_nxt     = 1'b0;
        w_refund_nxt     = 1'b0;
        w_complete_nxt   = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                if (cancel_req && (credit != '0)) begin
                    w_state_nxt      = ST_REFUND;
                    w_refund_gap_nxt = 1'b0;
                end else if (start_req && (credit >= w_price)) begin
                    w_base        = credit - w_price;
                    w_dw_nxt      = double_wash_req;
                    w_coin_in_nxt = 1'b1;
                    w_state_nxt   = ST_START;
                end
                // A coin arriving with a start is added after the deduction.
                if (r_coin_evt) begin
                    if (w_base == c_CREDIT_MAX) begin
                        w_reject_nxt = 1'b1;
                    end else begin
                        w_base = w_base + 1'b1;
                    end
                end
                w_credit_nxt = w_base;
            end
            ST_START: begin
                w_reject_nxt = r_coin_evt;
                w_state_nxt  = ST_BUSY;
            end
            ST_BUSY: begin
                w_reject_nxt = r_coin_evt;
                if (w_done_rise) begin
                    w_complete_nxt = 1'b1;
                    w_dw_nxt       = 1'b0;
                    w_state_nxt    = ST_COLLECT;
                end
            end
            ST_REFUND: begin
                w_reject_nxt = r_coin_evt;
                if (!r_refund_gap) begin
                    w_refund_nxt     = 1'b1;
                    w_credit_nxt     = credit - 1'b1;
                    w_refund_gap_nxt = 1'b1;
                end else if (credit == '0) begin
                    w_state_nxt = ST_COLLECT;
                end else begin
                    w_refund_gap_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_COLLECT;
            r_wash_done_q  <= 1'b0;
            r_refund_gap   <= 1'b0;
            credit         <= '0;
            double_wash    <= 1'b0;
            coin_in        <= 1'b0;
            coin_reject    <= 1'b0;
            refund_pulse   <= 1'b0;
            cycle_complete <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_wash_done_q  <= wash_done;
            r_refund_gap   <= w_refund_gap_nxt;
            credit         <= w_credit_nxt;
            double_wash    <= w_dw_nxt;
            coin_in        <= w_coin_in_nxt;
            coin_reject    <= w_reject_nxt;
            refund_pulse   <= w_refund_nxt;
            cycle_complete <= w_complete_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_coin_credit_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_credit_controller
// Brief    : Randomised scoreboard bench for coin_credit_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coin_credit_controller;

    localparam int PRICE_S  = 2;
    localparam int PRICE_D  = 3;
    localparam int DEB      = 16;
    localparam int CW       = 4;
    localparam int MAXC     = 15;

    localparam int EV_COIN_IN  = 0;
    localparam int EV_REJECT   = 1;
    localparam int EV_REFUND   = 2;
    localparam int EV_COMPLETE = 3;
    localparam int EV_CREDIT   = 4;

    localparam int M_COLLECT = 0;
    localparam int M_BUSY    = 1;
    localparam int M_REFUND  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          coin_sense;
    logic          double_wash_req;
    logic          start_req;
    logic          cancel_req;
    logic          wash_done;
    logic          coin_in;
    logic          double_wash;
    logic          busy;
    logic [CW-1:0] credit;
    logic          coin_reject;
    logic          refund_pulse;
    logic          cycle_complete;

    coin_credit_controller #(
        .PRICE_SINGLE    (PRICE_S),
        .PRICE_DOUBLE    (PRICE_D),
        .DEBOUNCE_CYCLES (DEB),
        .CREDIT_W        (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .coin_sense      (coin_sense),
        .double_wash_req (double_wash_req),
        .start_req       (start_req),
        .cancel_req      (cancel_req),
        .wash_done       (wash_done),
        .coin_in         (coin_in),
        .double_wash     (double_wash),
        .busy            (busy),
        .credit          (credit),
        .coin_reject     (coin_reject),
        .refund_pulse    (refund_pulse),
        .cycle_complete  (cycle_complete)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Reference model: abstract credit / mode / programme bookkeeping.
    int  m_credit = 0;
    int  m_state  = M_COLLECT;
    int  m_dw     = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic expect_ev(input int kind, input int val);
        ev_t e;
        n_checks++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event kind=%0d actual=%0d expected=none at %0t", kind, val, $time);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.val != val) begin
                n_fail++;
                $display("FAIL event actual kind=%0d val=%0d expected kind=%0d val=%0d at %0t",
                         kind, val, e.kind, e.val, $time);
            end
        end
    endtask

    // Monitor: every visible DUT response is matched against the scoreboard.
    int cyc = 0;
    int prev_credit = 0;
    int last_ref = -100;
    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_credit = 0;
                last_ref    = -100;
            end else begin
                if (coin_in) begin
                    expect_ev(EV_COIN_IN, int'(double_wash));
                    chk("busy_at_coin_in", int'(busy), 1);
                end
                if (coin_reject)
                    expect_ev(EV_REJECT, int'(credit));
                if (refund_pulse) begin
                    expect_ev(EV_REFUND, int'(credit));
                    if (cyc - last_ref < 10)
                        chk("refund_spacing", cyc - last_ref, 2);
                    last_ref = cyc;
                end
                if (cycle_complete)
                    expect_ev(EV_COMPLETE, int'({double_wash, busy}));
                if (int'(credit) != prev_credit)
                    expect_ev(EV_CREDIT, int'(credit));
                prev_credit = int'(credit);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic coin(input bit bounce);
        bit accept;
        int n;
        accept = (m_state == M_COLLECT) && (m_credit < MAXC);
        if (accept) begin
            m_credit++;
            push(EV_CREDIT, m_credit);
        end else begin
            push(EV_REJECT, m_credit);
        end
        if (bounce) begin
            for (int i = 0; i < 5; i++) begin
                coin_sense = ((i % 2) == 0) && (i < 4);
                tick(1);
            end
        end
        coin_sense = 1'b1;
        if (accept) begin
            // coin_evt lands 2+DEB cycles after the clean rise; credit one later.
            n = 0;
            while (int'(credit) != m_credit && n < 40) begin
                tick(1);
                n++;
            end
            chk("coin_latency", n, DEB + 3);
        end else begin
            tick(DEB + 5);
        end
        tick(3);
        coin_sense = 1'b0;
        tick(DEB + 6);
    endtask

    task automatic model_start(input int dw);
        int price;
        price = dw ? PRICE_D : PRICE_S;
        if (m_state == M_COLLECT && m_credit >= price) begin
            m_credit -= price;
            m_dw      = dw;
            m_state   = M_BUSY;
            push(EV_COIN_IN, dw);
            push(EV_CREDIT, m_credit);
        end
    endtask

    task automatic press_start(input int dw);
        model_start(dw);
        double_wash_req = dw[0];
        start_req = 1'b1;
        tick(1);
        start_req = 1'b0;
        double_wash_req = 1'($urandom_range(0, 1));
        tick(3);
        chk("busy_after_start", int'(busy), int'(m_state == M_BUSY));
        chk("double_wash_hold", int'(double_wash), m_dw);
        chk("credit_after_start", int'(credit), m_credit);
    endtask

    // Coin qualifies in the very cycle the FSM samples start_req.
    task automatic coin_with_start(input int dw);
        int price, old;
        bit was_collect, ok;
        price = dw ? PRICE_D : PRICE_S;
        old = m_credit;
        was_collect = (m_state == M_COLLECT);
        ok = was_collect && (m_credit >= price);
        if (ok) begin
            m_credit -= price;
            m_dw      = dw;
            m_state   = M_BUSY;
            push(EV_COIN_IN, dw);
        end
        if (was_collect && m_credit < MAXC) m_credit++;
        else push(EV_REJECT, m_credit);
        if (m_credit != old) push(EV_CREDIT, m_credit);
        double_wash_req = dw[0];
        coin_sense = 1'b1;
        tick(DEB + 2);
        start_req = 1'b1;
        tick(1);
        start_req = 1'b0;
        tick(3);
        chk("credit_start_coin", int'(credit), m_credit);
        coin_sense = 1'b0;
        tick(DEB + 6);
    endtask

    task automatic press_cancel(input bit also_start, input int dw, input bit full);
        int n;
        n = 0;
        if (m_state == M_COLLECT && m_credit > 0) begin
            n = m_credit;
            for (int c = n - 1; c >= 0; c--) begin
                push(EV_REFUND, c);
                push(EV_CREDIT, c);
            end
            m_credit = 0;
            m_state  = M_REFUND;
        end else if (also_start) begin
            model_start(dw);
        end
        double_wash_req = dw[0];
        cancel_req = 1'b1;
        start_req  = also_start;
        tick(1);
        cancel_req = 1'b0;
        start_req  = 1'b0;
        if (full) begin
            tick(2 * n + 4);
            if (m_state == M_REFUND) m_state = M_COLLECT;
            chk("credit_after_cancel", int'(credit), m_credit);
            chk("busy_after_cancel", int'(busy), int'(m_state == M_BUSY));
        end else begin
            tick(3);
        end
    endtask

    task automatic finish_wash(input int stale, input int low);
        tick(stale);
        wash_done = 1'b0;
        tick(low);
        if (m_state == M_BUSY) begin
            push(EV_COMPLETE, 0);
            m_state = M_COLLECT;
            m_dw    = 0;
        end
        wash_done = 1'b1;
        tick(3);
        chk("busy_after_done", int'(busy), int'(m_state == M_BUSY));
    endtask

    task automatic reset_mid();
        rst_n = 1'b0;
        q.delete();
        m_credit = 0;
        m_state  = M_COLLECT;
        m_dw     = 0;
        #2;
        chk("reset_outputs", int'({coin_in, double_wash, busy, coin_reject,
                                  refund_pulse, cycle_complete, credit}), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk("credit_after_reset", int'(credit), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int r;
        rst_n           = 1'b0;
        coin_sense      = 1'b0;
        double_wash_req = 1'b0;
        start_req       = 1'b0;
        cancel_req      = 1'b0;
        wash_done       = 1'b1;
        #2;
        chk("reset_outputs", int'({coin_in, double_wash, busy, coin_reject,
                                  refund_pulse, cycle_complete, credit}), 0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Three coins then a single-wash start.
        repeat (3) coin(1'b0);
        chk("credit_three_coins", int'(credit), 3);
        press_start(0);
        finish_wash(2, 3);

        // Bouncing sensor still gives exactly one coin.
        coin(1'b1);
        chk("credit_bounced", int'(credit), 2);

        // Double wash needs 3; first attempt refused.
        press_start(1);
        chk("start_insufficient", int'(credit), 2);
        coin(1'b0);
        press_start(1);
        coin(1'b0);
        finish_wash(3, 10);

        // Start and coin qualify in the same cycle.
        coin(1'b0);
        coin(1'b0);
        coin_with_start(0);
        finish_wash(1, 4);

        // Saturate, reject, then cancel-with-start refunds everything.
        while (m_credit < MAXC) coin(1'b0);
        coin(1'b0);
        chk("credit_saturated", int'(credit), MAXC);
        press_cancel(1'b1, 0, 1'b1);

        // Resets in the middle of a wash and of a refund.
        repeat (3) coin(1'b0);
        press_start(0);
        reset_mid();
        repeat (2) coin(1'b0);
        press_cancel(1'b0, 0, 1'b0);
        reset_mid();

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 99);
            if (m_state == M_BUSY && r < 50)
                finish_wash($urandom_range(0, 3), $urandom_range(1, 8));
            else if (r < 55)
                coin(1'($urandom_range(0, 1)));
            else if (r < 80)
                press_start($urandom_range(0, 1));
            else if (r < 90)
                press_cancel(1'b0, $urandom_range(0, 1), 1'b1);
            else
                press_cancel(1'b1, $urandom_range(0, 1), 1'b1);
        end

        tick(10);
        chk("scoreboard_drained", q.size(), 0);
        chk("final_credit", int'(credit), m_credit);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
